out_port_fifo: RTL

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

---
 rtl/out_port_fifo.sv | 75 +++++++
 1 files changed

// File: rtl/out_port_fifo.sv
// out_port_fifo: circular-buffer FIFO behind the CPU "out" port.
// Ports: clock, clear (sync active-low reset), BusMuxOut/e_OutPort (write side),
//        out_data/out_valid/out_ready (device side), full, empty, count, overflow.
module out_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         BusMuxOut,
    input  logic                     e_OutPort,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             push;
    logic             pop;

    assign empty     = (cnt == '0);
    assign full      = (cnt == FULL_CNT);
    assign out_valid = !empty;
    assign count     = cnt;
    assign overflow  = ovf;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign pop  = out_valid && out_ready;
    // A pop frees the slot on the same edge, so a full FIFO still accepts.
    assign push = e_OutPort && (!full || pop);

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (clear && push) begin
            mem[wr_ptr] <= BusMuxOut;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            if (e_OutPort && !push) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
